// File: rtl/sensores_pkg.sv
// Shared definitions for the two-beam vehicle sensor pair: command codes,
// generator state encoding and the per-command beam patterns.
package sensores_pkg;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_ENTRY = 2'b01;
    localparam logic [1:0] CMD_EXIT  = 2'b10;
    localparam logic [1:0] CMD_BALK  = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PH1  = 3'd1;
    localparam logic [2:0] ST_PH2  = 3'd2;
    localparam logic [2:0] ST_PH3  = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        PH1  = ST_PH1,
        PH2  = ST_PH2,
        PH3  = ST_PH3,
        GAP  = ST_GAP
    } gen_state_t;

    // Beam patterns as {a,b}
    localparam logic [1:0] PAT_ENTRY_1 = 2'b10;
    localparam logic [1:0] PAT_ENTRY_2 = 2'b11;
    localparam logic [1:0] PAT_ENTRY_3 = 2'b01;
    localparam logic [1:0] PAT_EXIT_1  = 2'b01;
    localparam logic [1:0] PAT_EXIT_2  = 2'b11;
    localparam logic [1:0] PAT_EXIT_3  = 2'b10;
    localparam logic [1:0] PAT_BALK_1  = 2'b10;
    localparam logic [1:0] PAT_BALK_2  = 2'b11;
    localparam logic [1:0] PAT_BALK_3  = 2'b10;

    // {a,b} driven while in state s playing command c; IDLE and GAP are dark.
    function automatic logic [1:0] phase_pattern(input logic [1:0] c, input gen_state_t s);
        logic [1:0] p;
        p = 2'b00;
        case (s)
            PH1: case (c)
                CMD_ENTRY: p = PAT_ENTRY_1;
                CMD_EXIT:  p = PAT_EXIT_1;
                CMD_BALK:  p = PAT_BALK_1;
                default:   p = 2'b00;
            endcase
            PH2: case (c)
                CMD_ENTRY: p = PAT_ENTRY_2;
                CMD_EXIT:  p = PAT_EXIT_2;
                CMD_BALK:  p = PAT_BALK_2;
                default:   p = 2'b00;
            endcase
            PH3: case (c)
                CMD_ENTRY: p = PAT_ENTRY_3;
                CMD_EXIT:  p = PAT_EXIT_3;
                CMD_BALK:  p = PAT_BALK_3;
                default:   p = 2'b00;
            endcase
            default: p = 2'b00;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sensores_gen_if.sv
// Command channel of the sensor stimulus generator.
interface sensores_gen_if #(
    parameter int DW = 16
) ();
    // A command transfers on a rising edge where cmd_valid && cmd_ready are both
    // high; cmd and dwell must be stable while cmd_valid is high, and cmd_ready
    // never depends combinationally on cmd_valid.
    logic          cmd_valid;
    logic [1:0]    cmd;
    logic [DW-1:0] dwell;
    logic          cmd_ready;

    modport master (
        output cmd_valid,
        output cmd,
        output dwell,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd,
        input  dwell,
        output cmd_ready
    );
endinterface

// File: rtl/sensores_dwell_timer.sv
// Phase-length down-counter: loads a value, counts to zero and holds there.
module sensores_dwell_timer #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    output logic          zero
);
    logic [DW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/sensores_gen.sv
// Two-beam sensor stimulus generator: plays entry/exit/balk a/b waveforms with
// a programmable dwell per phase, for self-test and decoder loop-back.
module sensores_gen
    import sensores_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic              clk,
    input  logic              reset,
    sensores_gen_if.slave     cmd_if,
    input  logic              abort,
    output logic              a,
    output logic              b,
    output logic              busy,
    output logic [1:0]        cur_cmd,
    output logic              done,
    output logic              aborted,
    output gen_state_t        state_dbg
);
    gen_state_t    state, state_n;
    logic [1:0]    cmd_n;
    logic [DW-1:0] dm1_q, dm1_n, in_dm1, load_val;
    logic          load, zero, accept;
    logic          done_n, aborted_n;
    logic [1:0]    ab_n;

    assign cmd_if.cmd_ready = (state == IDLE);
    assign state_dbg        = state;
    assign accept           = cmd_if.cmd_valid && cmd_if.cmd_ready && (cmd_if.cmd != CMD_NOP);
    // A dwell of 0 plays like 1; the counter holds D-1 so 0 means "last cycle".
    assign in_dm1           = (cmd_if.dwell == '0) ? '0 : cmd_if.dwell - 1'b1;

    sensores_dwell_timer #(.DW(DW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );

    always_comb begin
        state_n   = state;
        cmd_n     = cur_cmd;
        dm1_n     = dm1_q;
        load      = 1'b0;
        load_val  = dm1_q;
        done_n    = 1'b0;
        aborted_n = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n  = PH1;
                    cmd_n    = cmd_if.cmd;
                    dm1_n    = in_dm1;
                    load     = 1'b1;
                    load_val = in_dm1;
                end
            end
            default: begin
                // Abort takes priority, including over completion in the last GAP cycle.
                if (abort) begin
                    state_n   = IDLE;
                    cmd_n     = CMD_NOP;
                    aborted_n = 1'b1;
                end else if (zero) begin
                    load = 1'b1;
                    case (state)
                        PH1:     state_n = PH2;
                        PH2:     state_n = PH3;
                        PH3:     state_n = GAP;
                        default: begin
                            state_n = IDLE;
                            cmd_n   = CMD_NOP;
                            done_n  = 1'b1;
                            load    = 1'b0;
                        end
                    endcase
                end
            end
        endcase
        ab_n = phase_pattern(cmd_n, state_n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            a       <= 1'b0;
            b       <= 1'b0;
            busy    <= 1'b0;
            cur_cmd <= CMD_NOP;
            done    <= 1'b0;
            aborted <= 1'b0;
            dm1_q   <= '0;
        end else begin
            state   <= state_n;
            a       <= ab_n[1];
            b       <= ab_n[0];
            busy    <= (state_n != IDLE);
            cur_cmd <= cmd_n;
            done    <= done_n;
            aborted <= aborted_n;
            dm1_q   <= dm1_n;
        end
    end
endmodule

// File: tb/tb_sensores_gen.sv
// Scoreboard bench for sensores_gen: the driver queues the expected per-cycle
// observation vector, the monitor compares one vector on every falling edge.
module tb_sensores_gen;
    import sensores_pkg::*;

    localparam int DW = 16;
    localparam int W  = 8;

    logic       clk;
    logic       reset;
    logic       abort;
    logic       a, b, busy, done, aborted;
    logic [1:0] cur_cmd;
    gen_state_t state_dbg;

    sensores_gen_if #(.DW(DW)) cmd_if ();

    sensores_gen #(.DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_if    (cmd_if.slave),
        .abort     (abort),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .cur_cmd   (cur_cmd),
        .done      (done),
        .aborted   (aborted),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // Vector layout: {a, b, busy, cur_cmd[1:0], done, aborted, cmd_ready}
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc_idx  = 0;
    string        test_name = "none";

    function automatic logic [W-1:0] mk(input logic [1:0] ab, input logic bsy, input logic [1:0] cc,
                                        input logic dn, input logic ab_t, input logic rdy);
        return {ab, bsy, cc, dn, ab_t, rdy};
    endfunction

    // Hand-tabulated beam patterns, phase index 0..2.
    function automatic logic [1:0] tb_pat(input logic [1:0] c, input int ph);
        logic [1:0] p;
        p = 2'b00;
        if (c == 2'b01)      p = (ph == 0) ? 2'b10 : (ph == 1) ? 2'b11 : 2'b01;
        else if (c == 2'b10) p = (ph == 0) ? 2'b01 : (ph == 1) ? 2'b11 : 2'b10;
        else if (c == 2'b11) p = (ph == 0) ? 2'b10 : (ph == 1) ? 2'b11 : 2'b10;
        return p;
    endfunction

    always @(negedge clk) begin
        logic [W-1:0] got, exp_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got   = {a, b, busy, cur_cmd, done, aborted, cmd_if.cmd_ready};
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL %s cycle %0d: {a,b,busy,cur_cmd,done,aborted,ready} got %b expected %b",
                         test_name, cyc_idx, got, exp_v);
            end
            cyc_idx++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_test(input string name);
        test_name = name;
        cyc_idx   = 0;
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic push_done();
        exp_q.push_back(mk(2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1));
    endtask

    // Expected busy cycles first..last of a sequence (cycle 1 = first after accept).
    task automatic push_busy(input logic [1:0] c, input int d, input int first, input int last);
        int deff;
        int ph;
        logic [1:0] ab;
        deff = (d == 0) ? 1 : d;
        for (int k = first; k <= last; k++) begin
            ph = (k - 1) / deff;
            ab = (ph < 3) ? tb_pat(c, ph) : 2'b00;
            exp_q.push_back(mk(ab, 1'b1, c, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic issue(input logic [1:0] c, input int d);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd       = c;
        cmd_if.dwell     = DW'(d);
    endtask

    // Whole sequence: cycle 0 (idle), busy cycles, done cycle.
    task automatic run_cmd(input string name, input logic [1:0] c, input int d);
        int deff;
        deff = (d == 0) ? 1 : d;
        start_test(name);
        issue(c, d);
        push_idle(1);
        push_busy(c, d, 1, 4 * deff);
        push_done();
        step(1);
        cmd_if.cmd_valid = 1'b0;
        step(4 * deff + 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] exit_ab [8];
        exit_ab = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00};

        reset            = 1'b1;
        abort            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd       = 2'b00;
        cmd_if.dwell     = '0;
        step(3);
        reset = 1'b0;

        start_test("reset_idle");
        push_idle(11);
        step(11);

        run_cmd("entry_d3", CMD_ENTRY, 3);

        // Exit, dwell 2, against a literal waveform.
        start_test("exit_d2");
        issue(CMD_EXIT, 2);
        push_idle(1);
        for (int i = 0; i < 8; i++) exp_q.push_back(mk(exit_ab[i], 1'b1, CMD_EXIT, 1'b0, 1'b0, 1'b0));
        push_done();
        step(1);
        cmd_if.cmd_valid = 1'b0;
        step(9);

        run_cmd("balk_d2", CMD_BALK, 2);

        // dwell=0 then exit queued with valid held high.
        start_test("b2b_d0");
        issue(CMD_ENTRY, 0);
        push_idle(1);
        push_busy(CMD_ENTRY, 0, 1, 4);
        push_done();
        push_busy(CMD_EXIT, 0, 1, 4);
        push_done();
        step(1);
        cmd_if.cmd = CMD_EXIT;
        step(4);
        step(1);
        cmd_if.cmd_valid = 1'b0;
        step(5);

        // Abort in cycle 7 of entry d=5, exit accepted in cycle 8.
        start_test("abort");
        issue(CMD_ENTRY, 5);
        push_idle(1);
        push_busy(CMD_ENTRY, 5, 1, 7);
        exp_q.push_back(mk(2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1));
        push_busy(CMD_EXIT, 1, 1, 4);
        push_done();
        step(1);
        cmd_if.cmd_valid = 1'b0;
        step(6);
        abort = 1'b1;
        issue(CMD_EXIT, 1);
        step(1);
        abort = 1'b0;
        step(1);
        cmd_if.cmd_valid = 1'b0;
        step(5);

        // Abort in the final GAP cycle wins over done.
        start_test("abort_gap_end");
        issue(CMD_BALK, 1);
        push_idle(1);
        push_busy(CMD_BALK, 1, 1, 4);
        exp_q.push_back(mk(2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1));
        step(1);
        cmd_if.cmd_valid = 1'b0;
        step(3);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        step(1);

        // NOP command with valid, plus abort while idle: nothing happens.
        start_test("nop_and_idle_abort");
        issue(CMD_NOP, 4);
        push_idle(6);
        step(2);
        abort = 1'b1;
        step(2);
        abort = 1'b0;
        step(2);
        cmd_if.cmd_valid = 1'b0;

        // cmd/dwell churn while busy must not disturb the waveform.
        start_test("churn_while_busy");
        issue(CMD_ENTRY, 2);
        push_idle(1);
        push_busy(CMD_ENTRY, 2, 1, 8);
        push_done();
        step(1);
        for (int i = 0; i < 8; i++) begin
            cmd_if.cmd_valid = 1'($urandom_range(0, 1));
            cmd_if.cmd       = 2'($urandom_range(0, 3));
            cmd_if.dwell     = DW'($urandom_range(0, 9));
            step(1);
        end
        cmd_if.cmd_valid = 1'b0;
        step(1);

        // Reset in cycle 6 of entry d=3.
        start_test("reset_mid");
        issue(CMD_ENTRY, 3);
        push_idle(1);
        push_busy(CMD_ENTRY, 3, 1, 6);
        push_idle(1);
        step(1);
        cmd_if.cmd_valid = 1'b0;
        step(5);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);

        run_cmd("after_reset", CMD_EXIT, 1);

        // Bounded drain of anything still queued.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sensores_gen.md
Name: sensores_gen

Overview:
- Stimulus generator for the two-beam vehicle sensor pair: the transmit-side counterpart of the a/b direction decoder.
- On command, drives the a/b beam waveform of a vehicle passing in either direction, or one that enters and backs out. Each phase lasts a programmable number of cycles.
- Used for self-test and bench loop-back: its a/b outputs connect directly to the decoder's a/b inputs.

Parameters:
- DW, 16, width of the dwell (phase-length) field.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd  in  2  00=nop, 01=entry, 10=exit, 11=balk.
- dwell  in  DW  cycles per phase; sampled at accept.
- cmd_ready  out  1  high when a command can be accepted.
- abort  in  1  synchronous abort of the sequence in progress.
- a  out  1  beam A output, registered.
- b  out  1  beam B output, registered.
- busy  out  1  sequence in progress.
- cur_cmd  out  2  command being played; 00 when idle.
- done  out  1  one-cycle pulse when a sequence completes normally.
- aborted  out  1  one-cycle pulse when a sequence is aborted.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, a=b=0, busy=0, cur_cmd=00, done=0, aborted=0, dwell counter=0.
  - cmd_ready=1 in the first cycle after reset deasserts.
- States: IDLE, PH1, PH2, PH3, GAP.
- Patterns, as {a,b} in PH1/PH2/PH3, then GAP=00:
  - entry: 10 / 11 / 01.
  - exit: 01 / 11 / 10.
  - balk: 10 / 11 / 10.
- Handshake:
  - cmd_ready = (state==IDLE), derived from the state register.
  - Accept happens on a rising edge with cmd_valid && cmd_ready && cmd!=00.
  - cmd=00 with cmd_valid is ignored: no state change, no pulses.
- Dwell:
  - D = dwell sampled at accept; D=0 is treated as 1. Full DW-bit range is legal, no wrap.
  - Dwell counter loads D-1 on every phase entry and counts down; the phase advances when the counter is 0.
- Timing, with accept at edge E0 and cycles numbered after E0:
  - cycles 1..D: PH1.
  - cycles D+1..2D: PH2.
  - cycles 2D+1..3D: PH3.
  - cycles 3D+1..4D: GAP, a=b=0.
  - busy=1 and cur_cmd=cmd for cycles 1..4D.
  - Cycle 4D+1: state=IDLE, done=1 for one cycle, busy=0, cur_cmd=00, cmd_ready=1.
- Back-to-back: a command accepted at the end of cycle 4D+1 starts PH1 in cycle 4D+2. Minimum idle between sequences is 1 cycle.
- cmd and dwell changes while busy: ignored, no effect on the running sequence.
- Abort:
  - Abort sampled high while busy: next cycle a=b=0, state=IDLE, aborted=1 for one cycle, done=0, cur_cmd=00.
  - Abort while idle: no effect.
  - Abort and accept can never coincide, since accept requires IDLE.
  - Abort in the final GAP cycle: abort wins; aborted=1, done=0.
- Reset mid-sequence: all outputs return to reset values at the next edge; no done or aborted pulse.
- a, b, done and aborted come straight from flops; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package sensores_pkg:
  - command codes CMD_NOP, CMD_ENTRY, CMD_EXIT, CMD_BALK.
  - state encoding localparams for the generator FSM.
  - 2-bit phase pattern constants per command (PAT_ENTRY_1..3, etc.).
  - The decoder and this generator import the same package.
- One sub-module, sensores_dwell_timer:
  - DW-bit down-counter with load, load value, and zero flag.
  - Synchronous active-high reset.
  - Instantiated once.

Test Plan:
- Reset then idle: reset high 3 cycles, then low → a=b=0, busy=0, cmd_ready=1, no pulses for 10 cycles.
- Entry, dwell=3: accept at E0 → {a,b}=10 cycles 1-3, 11 cycles 4-6, 01 cycles 7-9, 00 cycles 10-12, done=1 only in cycle 13. Looping a/b into the decoder gives exactly one x0 pulse and no y0.
- Exit and balk, dwell=2:
  - exit → 01,01,11,11,10,10,00,00, then done in cycle 9.
  - balk → 10,10,11,11,10,10,00,00, then done; decoder gives no x0 and no y0.
- dwell=0 and back-to-back: dwell=0 behaves as dwell=1 (done in cycle 5). With cmd_valid held high and entry then exit queued, the second PH1 starts in cycle 6; cmd_ready is low in cycles 1-4.
- Abort: entry, dwell=5, abort pulsed in cycle 7 → cycle 8 has a=b=0, aborted=1, done=0, cmd_ready=1. A new command accepted in cycle 8 plays normally.
- Ignored inputs:
  - cmd=00 with valid → no activity.
  - cmd and dwell toggled while busy → waveform unchanged.
  - reset asserted in cycle 6 of a sequence → all outputs zero next cycle, no done or aborted.
